// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: sequences fetch requests, applies EX redirects, and
// parks a redirect while the instruction memory back-pressures.
module pc_fetch_ctrl #(
   parameter int PC_W   = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   input  logic              jalr_en,
   input  logic [DATA_W-1:0] jalr_target,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   pc,
   output logic [1:0]        pc_sel,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              redirect_pending
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [PC_W-1:0] pc_r, pc_s, pend_r, pend_s, target_s;
   logic            flush_r;
   logic            redirect_s, valid_s, accept_s;
   logic [1:0]      sel_s;
   logic            unused_jalr_s;

   // JALR targets are halfword-aligned by clearing bit 0; upper bits fall outside the PC space
   assign unused_jalr_s = ^{jalr_target[DATA_W-1:PC_W], jalr_target[0]};

   // Redirect source decode; JALR wins over a simultaneous branch
   always_comb begin
      redirect_s = 1'b0;
      sel_s      = 2'b00;
      target_s   = '0;
      if (!reset && (state_r != BOOT)) begin
         if (jalr_en) begin
            redirect_s = 1'b1;
            sel_s      = 2'b10;
            target_s   = {jalr_target[PC_W-1:1], 1'b0};
         end else if (br_taken) begin
            redirect_s = 1'b1;
            sel_s      = 2'b01;
            target_s   = br_target;
         end else begin
            redirect_s = 1'b0;
         end
      end else begin
         redirect_s = 1'b0;
      end
   end

   // Request valid per state; once raised in PEND it must stay up until accepted
   always_comb begin
      valid_s = 1'b0;
      case (state_r)
         BOOT:    valid_s = 1'b0;
         RUN:     valid_s = !stall;
         PEND:    valid_s = 1'b1;
         default: valid_s = 1'b0;
      endcase
   end

   assign accept_s = valid_s && imem_req_ready;

   // Next-state and next-PC selection
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      pend_s  = pend_r;
      case (state_r)
         BOOT: begin
            state_s = RUN;
            pc_s    = '0;
         end
         RUN: begin
            if (redirect_s) begin
               if (!valid_s || imem_req_ready) begin
                  pc_s = target_s;
               end else begin
                  pend_s  = target_s;
                  state_s = PEND;
               end
            end else if (accept_s) begin
               pc_s = pc_r + {{(PC_W-3){1'b0}}, 3'd4};
            end else begin
               pc_s = pc_r;
            end
         end
         PEND: begin
            // the youngest redirect replaces whatever target is parked
            if (accept_s) begin
               state_s = RUN;
               pc_s    = redirect_s ? target_s : pend_r;
            end else if (redirect_s) begin
               pend_s = target_s;
            end else begin
               pend_s = pend_r;
            end
         end
         default: begin
            state_s = BOOT;
            pc_s    = '0;
            pend_s  = '0;
         end
      endcase
   end

   // State, PC, parked target and flush registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= BOOT;
         pc_r    <= '0;
         pend_r  <= '0;
         flush_r <= 1'b0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         pend_r  <= pend_s;
         flush_r <= redirect_s;
      end
   end

   assign imem_req_valid   = valid_s;
   assign pc               = pc_r;
   assign pc_sel           = sel_s;
   assign flush_if_id      = flush_r;
   assign flush_id_ex      = flush_r;
   assign redirect_pending = (state_r == PEND);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: per-cycle vector table plus hand-written
// back-pressure / stall sequences.
module tb_pc_fetch_ctrl;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [8:0]  br_target;
   logic        jalr_en;
   logic [31:0] jalr_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [8:0]  pc;
   logic [1:0]  pc_sel;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        redirect_pending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        br;
      logic [8:0]  brt;
      logic        jalr;
      logic [31:0] jt;
      logic        rdy;
      logic        e_val;
      logic [8:0]  e_pc;
      logic [1:0]  e_sel;
      logic        e_fl;
      logic        e_pd;
   } vec_t;

   vec_t vq[$];

   pc_fetch_ctrl #(.PC_W(9), .DATA_W(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .br_taken         (br_taken),
      .br_target        (br_target),
      .jalr_en          (jalr_en),
      .jalr_target      (jalr_target),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .pc               (pc),
      .pc_sel           (pc_sel),
      .flush_if_id      (flush_if_id),
      .flush_id_ex      (flush_id_ex),
      .redirect_pending (redirect_pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic b, input logic [8:0] bt,
                        input logic j, input logic [31:0] jt, input logic rd);
      reset          = r;
      stall          = s;
      br_taken       = b;
      br_target      = bt;
      jalr_en        = j;
      jalr_target    = jt;
      imem_req_ready = rd;
   endtask

   task automatic chk_outs(input string tag, input logic v, input logic [8:0] p,
                           input logic [1:0] sl, input logic fl, input logic pd);
      chk({tag, ".valid"},   {31'd0, imem_req_valid},   {31'd0, v});
      chk({tag, ".pc"},      {23'd0, pc},               {23'd0, p});
      chk({tag, ".pc_sel"},  {30'd0, pc_sel},           {30'd0, sl});
      chk({tag, ".flush"},   {30'd0, flush_if_id, flush_id_ex}, {30'd0, fl, fl});
      chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, pd});
   endtask

   initial begin
      bit done;

      //         rst   stl   br    brt     jalr  jt             rdy   val   pc      sel    fl    pd
      vq.push_back('{1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h000, 2'b00, 1'b0, 1'b0}); // 0 reset
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h000, 2'b00, 1'b0, 1'b0}); // 1 BOOT
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h000, 2'b00, 1'b0, 1'b0}); // 2
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h004, 2'b00, 1'b0, 1'b0}); // 3
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h008, 2'b00, 1'b0, 1'b0}); // 4
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h040, 1'b0, 32'h0,        1'b1, 1'b1, 9'h00C, 2'b01, 1'b0, 1'b0}); // 5 branch
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h040, 2'b00, 1'b1, 1'b0}); // 6
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h080, 1'b1, 32'hFFFF0123, 1'b1, 1'b1, 9'h044, 2'b10, 1'b0, 1'b0}); // 7 jalr+br
      vq.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h122, 2'b00, 1'b1, 1'b0}); // 8 stall
      vq.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h122, 2'b00, 1'b0, 1'b0}); // 9
      vq.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h122, 2'b00, 1'b0, 1'b0}); // 10
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 9'h122, 2'b00, 1'b0, 1'b0}); // 11 not ready
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h0A0, 1'b0, 32'h0,        1'b0, 1'b1, 9'h122, 2'b01, 1'b0, 1'b0}); // 12 -> PEND
      vq.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 9'h122, 2'b00, 1'b1, 1'b1}); // 13 stall in PEND
      vq.push_back('{1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 9'h122, 2'b00, 1'b0, 1'b1}); // 14
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h122, 2'b00, 1'b0, 1'b1}); // 15 accept
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h0A0, 2'b00, 1'b0, 1'b0}); // 16
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h100, 1'b0, 32'h0,        1'b0, 1'b1, 9'h0A4, 2'b01, 1'b0, 1'b0}); // 17 -> PEND
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 32'h00000031, 1'b0, 1'b1, 9'h0A4, 2'b10, 1'b1, 1'b1}); // 18 overwrite
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h0A4, 2'b00, 1'b1, 1'b1}); // 19 accept
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h030, 2'b00, 1'b0, 1'b0}); // 20
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h1F0, 1'b0, 32'h0,        1'b0, 1'b1, 9'h034, 2'b01, 1'b0, 1'b0}); // 21 -> PEND
      vq.push_back('{1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b0, 1'b1, 9'h034, 2'b00, 1'b1, 1'b1}); // 22 reset in PEND
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b0, 9'h000, 2'b00, 1'b0, 1'b0}); // 23 BOOT
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h000, 2'b00, 1'b0, 1'b0}); // 24
      vq.push_back('{1'b0, 1'b0, 1'b1, 9'h1FC, 1'b0, 32'h0,        1'b1, 1'b1, 9'h004, 2'b01, 1'b0, 1'b0}); // 25
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h1FC, 2'b00, 1'b1, 1'b0}); // 26 wrap
      vq.push_back('{1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0,        1'b1, 1'b1, 9'h000, 2'b00, 1'b0, 1'b0}); // 27

      drive(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0, 1'b1);
      repeat (2) @(posedge clk);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].stl, vq[i].br, vq[i].brt, vq[i].jalr, vq[i].jt, vq[i].rdy);
         #1;
         chk_outs($sformatf("vec%0d", i), vq[i].e_val, vq[i].e_pc, vq[i].e_sel, vq[i].e_fl, vq[i].e_pd);
      end

      // redirect during stall applies directly since no request is outstanding
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 32'h0, 1'b0);
      #1;
      chk_outs("stall_redir", 1'b0, 9'h004, 2'b01, 1'b0, 1'b0);

      // back-pressured redirect from pc 0x010 parks the target
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 9'h0A0, 1'b0, 32'h0, 1'b0);
      #1;
      chk_outs("bp_redir", 1'b1, 9'h010, 2'b01, 1'b1, 1'b0);

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 32'h0, 1'b0);
         #1;
         chk_outs($sformatf("pend_hold%0d", k), 1'b1, 9'h010, 2'b00, (k == 0), 1'b1);
      end

      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 32'h0, 1'b1);
      done = 1'b0;
      for (int k = 0; k < 4 && !done; k++) begin
         @(posedge clk);
         #1;
         if (!redirect_pending) done = 1'b1;
      end
      chk("pend_release", {31'd0, done}, 32'd1);
      chk("pend_target", {23'd0, pc}, 32'h0A0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
